pixel_mem_arb: RTL

PIXEL_MEM_ARB -- requirements
Module: pixel_mem_arb

---
 rtl/pixel_mem_arb_if.sv | 44 ++++
 rtl/pixel_mem_arb.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pixel_mem_arb_if.sv
// Bus bundle for pixel_mem_arb.
// Port A carries NUM_REQ arbitrated requesters with flattened address and data
// fields. Port B is a single dedicated access port.
interface pixel_mem_arb_if #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int NUM_REQ = 2
);
    localparam int RID_W = $clog2(NUM_REQ);

    // Port A: arbitrated requesters
    logic [NUM_REQ-1:0]        req_a;
    logic [NUM_REQ-1:0]        wen_a;
    logic [NUM_REQ*ADDR_W-1:0] addr_a;
    logic [NUM_REQ*DATA_W-1:0] wdata_a;
    logic [NUM_REQ-1:0]        gnt_a;
    logic                      rvalid_a;
    logic [DATA_W-1:0]         rdata_a;
    logic [RID_W-1:0]          rid_a;

    // Port B: dedicated access
    logic                      en_b;
    logic                      wen_b;
    logic [ADDR_W-1:0]         addr_b;
    logic [DATA_W-1:0]         wdata_b;
    logic                      rvalid_b;
    logic [DATA_W-1:0]         rdata_b;

    // Requester side: drives requests, receives grants and read data
    modport master (
        output req_a, wen_a, addr_a, wdata_a,
        output en_b, wen_b, addr_b, wdata_b,
        input  gnt_a, rvalid_a, rdata_a, rid_a,
        input  rvalid_b, rdata_b
    );

    // Memory side: receives requests, returns grants and read data
    modport slave (
        input  req_a, wen_a, addr_a, wdata_a,
        input  en_b, wen_b, addr_b, wdata_b,
        output gnt_a, rvalid_a, rdata_a, rid_a,
        output rvalid_b, rdata_b
    );
endinterface

// File: rtl/pixel_mem_arb.sv
// Dual-port pixel memory with a round-robin arbiter on port A.
// Port A serves NUM_REQ requesters, one per cycle, chosen by scanning upward
// from a rotating pointer. Port B is a dedicated port that is never arbitrated.
// Both ports read with one cycle of latency and return the pre-write word when
// a read and a write hit the same address on the same edge. When both ports
// write the same address together, port A's data is the one kept.
module pixel_mem_arb #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 10,
    parameter int NUM_REQ = 2
) (
    input  logic           clk,
    input  logic           n_rst,
    pixel_mem_arb_if.slave bus
);
    localparam int             RID_W     = $clog2(NUM_REQ);
    localparam int             DEPTH     = 2 ** ADDR_W;
    localparam logic [RID_W:0] NUM_REQ_W = (RID_W + 1)'(NUM_REQ);
    localparam logic [RID_W-1:0] LAST_REQ = RID_W'(NUM_REQ - 1);

    // Storage
    logic [DATA_W-1:0] mem [DEPTH];

    // Arbitration
    logic [RID_W-1:0]     ptr;
    logic [RID_W-1:0]     ptr_nxt;
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [RID_W-1:0]     rot_off;
    logic [RID_W:0]       idx_sum;
    logic [RID_W-1:0]     gnt_idx;
    logic                 gnt_any;
    logic [NUM_REQ-1:0]   gnt;

    // Granted requester's access
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_wen;

    // Per-port access strobes for this edge
    logic                 a_wr;
    logic                 a_rd;
    logic                 b_wr;
    logic                 b_rd;

    // Registered read results
    logic                 a_valid;
    logic [DATA_W-1:0]    a_data;
    logic [RID_W-1:0]     a_rid;
    logic                 b_valid;
    logic [DATA_W-1:0]    b_data;

    // Round-robin search: rotate requests so ptr sits at bit 0, take the lowest
    // set bit, then rotate the winning offset back to an absolute index.
    // NOTE: combinational blocks use blocking '=' and give every output a
    // default first, so each signal is fully assigned on every path and no
    // latch is inferred.
    always_comb begin
        req_dbl = {bus.req_a, bus.req_a} >> ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        gnt_any = |bus.req_a;
        rot_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_off = RID_W'(k);
            end
        end
        idx_sum = {1'b0, ptr} + {1'b0, rot_off};
        if (idx_sum >= NUM_REQ_W) begin
            idx_sum = idx_sum - NUM_REQ_W;
        end
        gnt_idx = idx_sum[RID_W-1:0];
        gnt     = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
        ptr_nxt = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
    end

    // Route the granted requester's address, data and direction to the array
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wen   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = bus.addr_a[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.wdata_a[i*DATA_W +: DATA_W];
                sel_wen   = bus.wen_a[i];
            end
        end
    end

    // Access strobes; nothing touches the array while reset is held
    always_comb begin
        a_wr = n_rst & gnt_any & sel_wen;
        a_rd = n_rst & gnt_any & ~sel_wen;
        b_wr = n_rst & bus.en_b & bus.wen_b;
        b_rd = n_rst & bus.en_b & ~bus.wen_b;
    end

    // Array write: port A is applied last so it wins a same-address collision
    // NOTE: the array has no reset branch; contents survive reset, and a reset
    // term here would prevent block-RAM inference.
    always_ff @(posedge clk) begin
        if (b_wr) begin
            mem[bus.addr_b] <= bus.wdata_b;
        end
        if (a_wr) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Port A: pointer advance and registered read (old data on collision)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr     <= '0;
            a_valid <= 1'b0;
            a_data  <= '0;
            a_rid   <= '0;
        end else begin
            if (gnt_any) begin
                ptr <= ptr_nxt;
            end
            a_valid <= a_rd;
            if (a_rd) begin
                a_data <= mem[sel_addr];
                a_rid  <= gnt_idx;
            end
        end
    end

    // Port B: registered read (old data on collision)
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            b_valid <= 1'b0;
            b_data  <= '0;
        end else begin
            b_valid <= b_rd;
            if (b_rd) begin
                b_data <= mem[bus.addr_b];
            end
        end
    end

    assign bus.gnt_a    = gnt;
    assign bus.rvalid_a = a_valid;
    assign bus.rdata_a  = a_data;
    assign bus.rid_a    = a_rid;
    assign bus.rvalid_b = b_valid;
    assign bus.rdata_b  = b_data;

endmodule
